// File: rtl/fp32_add_mul_if.sv
// Operand/result bundle shared by the binary32 adder and multiplier.
// X/Y are held by the requester; Z/done come back from the unit.
interface fp32_add_mul_if;
    logic [31:0] X;
    logic [31:0] Y;
    logic [31:0] Z;
    logic        done;

    modport master (output X, Y, input Z, done);
    modport slave  (input X, Y, output Z, done);
endinterface

// File: rtl/fp32_add_mul.sv
// Multi-cycle binary32 adder and multiplier (RNE, subnormals, x86 NaNs).
// Each operation starts on reset release and completes 5 edges later.
module fp32_unit #(
    parameter bit MUL = 1'b0
) (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Z,
    output logic        done
);
    typedef enum logic [2:0] {
        IDLE, UNPACK, COMPUTE, NORMALIZE, ROUND, DONE
    } state_t;

    state_t             state_q;
    logic [31:0]        x_q, y_q, spec_z_q, z_q;
    logic               spec_q, sa_q, sb_q, sign_q;
    logic               g_q, rs_q, done_q;
    logic [23:0]        ma_q, mb_q, man_q;
    logic [7:0]         ea_q, eb_q;
    logic signed [10:0] exp_q;
    logic [47:0]        sig_q;

    function automatic logic [5:0] lzc48(input logic [47:0] v);
        logic [5:0] n;
        n = 6'd48;
        for (int i = 0; i < 48; i++)
            if (v[i]) n = 6'(47 - i);
        return n;
    endfunction

    logic        xn, yn, xi, yi, xz, yz;
    logic        spec_d;
    logic [31:0] spec_z_d;

    assign xn = (&x_q[30:23]) & (|x_q[22:0]);
    assign yn = (&y_q[30:23]) & (|y_q[22:0]);
    assign xi = (&x_q[30:23]) & ~(|x_q[22:0]);
    assign yi = (&y_q[30:23]) & ~(|y_q[22:0]);
    assign xz = ~(|x_q[30:0]);
    assign yz = ~(|y_q[30:0]);

    always_comb begin
        spec_d   = 1'b1;
        spec_z_d = 32'h0000_0000;
        if (xn) begin
            spec_z_d = x_q | 32'h0040_0000;
        end else if (yn) begin
            spec_z_d = y_q | 32'h0040_0000;
        end else if (MUL) begin
            if ((xi && yz) || (yi && xz))
                spec_z_d = 32'hFFC0_0000;
            else if (xi || yi)
                spec_z_d = {x_q[31] ^ y_q[31], 31'h7F80_0000};
            else
                spec_d = 1'b0;
        end else begin
            if (xi && yi && (x_q[31] != y_q[31]))
                spec_z_d = 32'hFFC0_0000;
            else if (xi)
                spec_z_d = x_q;
            else if (yi)
                spec_z_d = y_q;
            else
                spec_d = 1'b0;
        end
    end

    logic               swap, bs;
    logic [23:0]        bm, sm;
    logic [7:0]         be, se, dexp;
    logic [26:0]        sx, al;
    logic [27:0]        sum;
    logic [47:0]        cmp_sig_d;
    logic signed [10:0] cmp_exp_d;
    logic               cmp_sign_d;

    // Adder keeps 3 extra bits (guard, round, sticky) below the significand.
    always_comb begin
        swap = {eb_q, mb_q} > {ea_q, ma_q};
        bm   = swap ? mb_q : ma_q;
        sm   = swap ? ma_q : mb_q;
        be   = swap ? eb_q : ea_q;
        se   = swap ? ea_q : eb_q;
        bs   = swap ? sb_q : sa_q;
        dexp = be - se;
        sx   = {sm, 3'b000};
        if (dexp >= 8'd27) begin
            al = {26'd0, |sm};
        end else begin
            al    = sx >> dexp;
            al[0] = al[0] | (|(sx & ((27'd1 << dexp) - 27'd1)));
        end
        if (sa_q == sb_q)
            sum = {1'b0, bm, 3'b000} + {1'b0, al};
        else
            sum = {1'b0, bm, 3'b000} - {1'b0, al};
        if (MUL) begin
            cmp_sig_d  = {24'd0, ma_q} * {24'd0, mb_q};
            cmp_exp_d  = $signed({3'b000, ea_q}) + $signed({3'b000, eb_q})
                       - 11'sd127;
            cmp_sign_d = sa_q ^ sb_q;
        end else begin
            cmp_sig_d  = {sum, 20'd0};
            cmp_exp_d  = $signed({3'b000, be});
            cmp_sign_d = (sum == 28'd0) ? (sa_q & sb_q) : bs;
        end
    end

    logic [5:0]         lz;
    logic signed [10:0] lz_s, en, k;
    logic [10:0]        rsh;
    logic [46:0]        nrm;
    logic               nst;

    // Hidden bit lands at sig[46]; below exponent 1 shift right instead.
    always_comb begin
        lz   = lzc48(sig_q);
        lz_s = $signed({5'd0, lz});
        en   = exp_q + 11'sd1 - lz_s;
        k    = (en >= 11'sd1) ? lz_s - 11'sd1 : exp_q - 11'sd1;
        rsh  = -k;
        nst  = 1'b0;
        if (k >= 11'sd0) begin
            nrm = 47'(sig_q << k[5:0]);
        end else if (rsh >= 11'd48) begin
            nrm = 47'd0;
            nst = |sig_q;
        end else begin
            nrm = 47'(sig_q >> rsh);
            nst = |(sig_q & ((48'd1 << rsh) - 48'd1));
        end
    end

    logic               inc;
    logic [24:0]        mr;
    logic [23:0]        rm;
    logic signed [10:0] re;
    logic [31:0]        rnd_z;

    always_comb begin
        inc = g_q & (rs_q | man_q[0]);
        mr  = {1'b0, man_q} + {24'd0, inc};
        rm  = mr[24] ? mr[24:1] : mr[23:0];
        re  = mr[24] ? exp_q + 11'sd1 : exp_q;
        if (!rm[23])
            rnd_z = {sign_q, 8'd0, rm[22:0]};
        else if (re >= 11'sd255)
            rnd_z = {sign_q, 31'h7F80_0000};
        else
            rnd_z = {sign_q, re[7:0], rm[22:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            spec_q   <= 1'b0;
            spec_z_q <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ma_q     <= '0;
            mb_q     <= '0;
            ea_q     <= '0;
            eb_q     <= '0;
            sig_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            man_q    <= '0;
            g_q      <= 1'b0;
            rs_q     <= 1'b0;
            z_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    x_q     <= X;
                    y_q     <= Y;
                    state_q <= UNPACK;
                end
                UNPACK: begin
                    sa_q     <= x_q[31];
                    sb_q     <= y_q[31];
                    ea_q     <= (x_q[30:23] == 8'd0) ? 8'd1 : x_q[30:23];
                    eb_q     <= (y_q[30:23] == 8'd0) ? 8'd1 : y_q[30:23];
                    ma_q     <= {|x_q[30:23], x_q[22:0]};
                    mb_q     <= {|y_q[30:23], y_q[22:0]};
                    spec_q   <= spec_d;
                    spec_z_q <= spec_z_d;
                    state_q  <= COMPUTE;
                end
                COMPUTE: begin
                    sig_q   <= cmp_sig_d;
                    exp_q   <= cmp_exp_d;
                    sign_q  <= cmp_sign_d;
                    state_q <= NORMALIZE;
                end
                NORMALIZE: begin
                    man_q   <= nrm[46:23];
                    g_q     <= nrm[22];
                    rs_q    <= (|nrm[21:0]) | nst;
                    exp_q   <= (en >= 11'sd1) ? en : 11'sd1;
                    state_q <= ROUND;
                end
                ROUND: begin
                    z_q     <= spec_q ? spec_z_q : rnd_z;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Z    = z_q;
    assign done = done_q;
endmodule

module adder (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Z,
    output logic        done
);
    fp32_unit #(.MUL(1'b0)) u_core (X, Y, clk, reset, Z, done);
endmodule

module multiplier (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Z,
    output logic        done
);
    fp32_unit #(.MUL(1'b1)) u_core (X, Y, clk, reset, Z, done);
endmodule

module fp32_add_mul (
    input logic           clk,
    input logic           reset,
    fp32_add_mul_if.slave add_if,
    fp32_add_mul_if.slave mul_if
);
    adder u_add (add_if.X, add_if.Y, clk, reset, add_if.Z, add_if.done);
    multiplier u_mul (mul_if.X, mul_if.Y, clk, reset, mul_if.Z, mul_if.done);
endmodule

// File: tb/tb_fp32_add_mul.sv
// Scoreboard bench for fp32_add_mul: directed vectors, control cases
// and random operands against a double-precision host reference.
module tb_fp32_add_mul;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;
    int na = 0;
    int nm = 0;
    logic [31:0] q_add[$];
    logic [31:0] q_mul[$];
    bit a_seen = 1'b0;
    bit m_seen = 1'b0;

    fp32_add_mul_if aif();
    fp32_add_mul_if mif();

    fp32_add_mul dut (
        .clk(clk),
        .reset(rst_n),
        .add_if(aif),
        .mul_if(mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm_s, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", nm_s, got, want);
        end
    endtask

    function automatic real from_f32(input logic [31:0] f);
        real v;
        int ee;
        ee = (f[30:23] == 8'd0) ? 1 : int'(f[30:23]);
        v = real'({f[30:23] != 8'd0, f[22:0]}) * (2.0 ** real'(ee - 150));
        return f[31] ? -v : v;
    endfunction

    // double -> binary32, round to nearest even, with subnormals
    function automatic logic [31:0] to_f32(input real r);
        logic [63:0] b, m, q, rem, half, v;
        int e, sh;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'd0};
        e = int'(b[62:52]) - 1023 + 127;
        m = {11'd0, 1'b1, b[51:0]};
        sh = (e >= 1) ? 29 : 29 + 1 - e;
        if (sh > 60) return {b[63], 31'd0};
        q = m >> sh;
        rem = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        v = ((e >= 1) ? (64'(e - 1) << 23) : 64'd0) + q;
        if (v >= 64'h7F80_0000) v = 64'h7F80_0000;
        return {b[63], v[30:0]};
    endfunction

    always @(negedge clk) begin
        if (aif.done && !a_seen) begin
            a_seen = 1'b1;
            if (q_add.size() == 0) begin
                total++;
                bad++;
                $display("FAIL add_unexpected: got %08h want none", aif.Z);
            end else begin
                check($sformatf("add#%0d", na), aif.Z, q_add.pop_front());
            end
            na++;
        end
        if (!aif.done) a_seen = 1'b0;
        if (mif.done && !m_seen) begin
            m_seen = 1'b1;
            if (q_mul.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mul_unexpected: got %08h want none", mif.Z);
            end else begin
                check($sformatf("mul#%0d", nm), mif.Z, q_mul.pop_front());
            end
            nm++;
        end
        if (!mif.done) m_seen = 1'b0;
    end

    task automatic issue(input logic [31:0] ax, ay, mx, my);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        aif.X = ax;
        aif.Y = ay;
        mif.X = mx;
        mif.Y = my;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run(input logic [31:0] ax, ay, mx, my, ea, em);
        q_add.push_back(ea);
        q_mul.push_back(em);
        issue(ax, ay, mx, my);
        repeat (4) @(posedge clk);
        #1;
        check("lat4_add_done", {31'd0, aif.done}, 32'd0);
        check("lat4_mul_done", {31'd0, mif.done}, 32'd0);
        @(posedge clk);
        #1;
        check("lat5_add_done", {31'd0, aif.done}, 32'd1);
        check("lat5_mul_done", {31'd0, mif.done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        aif.X = '0;
        aif.Y = '0;
        mif.X = '0;
        mif.Y = '0;
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_add_z", aif.Z, 32'h0);
        check("rst_add_done", {31'd0, aif.done}, 32'd0);
        check("rst_mul_z", mif.Z, 32'h0);
        check("rst_mul_done", {31'd0, mif.done}, 32'd0);

        run(32'h3F80_0000, 32'h4000_0000, 32'h3FC0_0000, 32'h4000_0000,
            32'h4040_0000, 32'h4040_0000);
        repeat (20) @(posedge clk);
        #1;
        check("hold_add_z", aif.Z, 32'h4040_0000);
        check("hold_mul_done", {31'd0, mif.done}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("clr_add_z", aif.Z, 32'h0);
        check("clr_add_done", {31'd0, aif.done}, 32'd0);
        check("clr_mul_z", mif.Z, 32'h0);

        run(32'h3F80_0000, 32'hBF80_0000, 32'h8000_0000, 32'h3F80_0000,
            32'h0000_0000, 32'h8000_0000);
        run(32'h8000_0000, 32'h8000_0000, 32'h0080_0000, 32'h3F00_0000,
            32'h8000_0000, 32'h0040_0000);
        run(32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h3F00_0000,
            32'h0000_0002, 32'h0000_0000);
        run(32'h4B80_0000, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h4000_0000,
            32'h4B80_0000, 32'h7F80_0000);
        run(32'h4B80_0001, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000,
            32'h4B80_0002, 32'hFFC0_0000);
        run(32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0001,
            32'hFFC0_0000, 32'hFFC0_0001);
        run(32'h7F80_0001, 32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000,
            32'h7FC0_0001, 32'hFF80_0000);
        run(32'h0080_0000, 32'h8000_0001, 32'h3F80_0001, 32'h3F80_0001,
            32'h007F_FFFF, 32'h3F80_0002);
        run(32'h4000_0000, 32'hC040_0000, 32'h4000_0000, 32'hC040_0000,
            32'hBF80_0000, 32'hC0C0_0000);

        // abort two edges into an operation, then restart
        issue(32'h4120_0000, 32'h4120_0000, 32'h4120_0000, 32'h4120_0000);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_add_z", aif.Z, 32'h0);
        check("abort_add_done", {31'd0, aif.done}, 32'd0);
        check("abort_mul_done", {31'd0, mif.done}, 32'd0);
        run(32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000,
            32'h4000_0000, 32'h4110_0000);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 3))
                1: y[30:23] = x[30:23] + 8'($urandom_range(0, 3));
                2: y = {~x[31], x[30:0]} ^ 32'($urandom_range(0, 7));
                3: begin
                    x[30:23] = 8'($urandom_range(0, 3));
                    y[30:23] = 8'($urandom_range(0, 130));
                end
                default: ;
            endcase
            if (&x[30:23]) x[30] = 1'b0;
            if (&y[30:23]) y[30] = 1'b0;
            run(x, y, x, y,
                to_f32(from_f32(x) + from_f32(y)),
                to_f32(from_f32(x) * from_f32(y)));
        end

        repeat (5) @(posedge clk);
        #1;
        check("add_queue_left", 32'(q_add.size()), 32'd0);
        check("mul_queue_left", 32'(q_mul.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
